// File: rtl/omsp_spm_key_loader.sv
`timescale 1ns/1ps
// Key loader: starts the key-derivation engine and writes the derived key word by word into a new SPM.
// Define OMSP_SPM_KEY_ZEROIZE_EN to overwrite a partially written key with zeros before raising error.
module omsp_spm_key_loader #(
    parameter int KEY_WORDS    = 4,
    parameter int KEY_IDX_SIZE = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                    mclk,
    input  logic                    puc_rst,
    input  logic                    start,
    input  logic                    abort,
    output logic                    kdf_start,
    input  logic                    kdf_valid,
    input  logic [15:0]             kdf_data,
    output logic                    kdf_ready,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [2:0]              dbg_state
);

    localparam int                      TCNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = KEY_IDX_SIZE'(KEY_WORDS - 1);
    localparam logic [TCNT_W-1:0]       TCNT_MAX = TCNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_KICK = 3'd1,
        S_LOAD = 3'd2,
        S_DONE = 3'd3,
`ifdef OMSP_SPM_KEY_ZEROIZE_EN
        S_ZERO = 3'd4,
`endif
        S_ERR  = 3'd5
    } state_t;

`ifdef OMSP_SPM_KEY_ZEROIZE_EN
    localparam state_t FAIL_STATE = S_ZERO;
`else
    localparam state_t FAIL_STATE = S_ERR;
`endif

    state_t                  state;
    state_t                  state_nxt;
    logic [KEY_IDX_SIZE-1:0] widx;
    logic [TCNT_W-1:0]       tcnt;
    logic                    hs;
    logic                    fail_go;
    logic                    accept;

    // Valid/ready: a key word transfers on every cycle where kdf_valid and kdf_ready are both
    // high; kdf_ready is high only in LOAD, so kdf_valid elsewhere is never acknowledged.
    always_comb begin
        state_nxt = state;
        hs        = 1'b0;
        fail_go   = 1'b0;
        accept    = 1'b0;
        kdf_start = 1'b0;
        kdf_ready = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = S_KICK;
                end
            end
            S_KICK: begin
                kdf_start = 1'b1;
                if (abort) fail_go = 1'b1;
                else       state_nxt = S_LOAD;
            end
            S_LOAD: begin
                kdf_ready = 1'b1;
                hs        = kdf_valid;
                // Abort beats a final-word handshake; the word itself is still written.
                if (abort || (!hs && tcnt == TCNT_MAX)) fail_go = 1'b1;
                else if (hs && widx == LAST_IDX)       state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (abort) fail_go = 1'b1;
                else       state_nxt = S_IDLE;
            end
`ifdef OMSP_SPM_KEY_ZEROIZE_EN
            S_ZERO: begin
                if (widx == LAST_IDX) state_nxt = S_ERR;
            end
`endif
            S_ERR: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (fail_go) state_nxt = FAIL_STATE;
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state     <= S_IDLE;
            widx      <= '0;
            tcnt      <= '0;
            write_key <= 1'b0;
            key_in    <= '0;
            key_idx   <= '0;
            error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            write_key <= 1'b0;
            if (accept) begin
                error <= 1'b0;
                widx  <= '0;
                tcnt  <= '0;
            end
            if (hs) begin
                write_key <= 1'b1;
                key_in    <= kdf_data;
                key_idx   <= widx;
                tcnt      <= '0;
                if (widx != LAST_IDX) widx <= widx + 1'b1;
            end else if (state == S_LOAD && tcnt != TCNT_MAX) begin
                tcnt <= tcnt + 1'b1;
            end
`ifdef OMSP_SPM_KEY_ZEROIZE_EN
            if (state == S_ZERO) begin
                write_key <= 1'b1;
                key_in    <= '0;
                key_idx   <= widx;
                if (widx != LAST_IDX) widx <= widx + 1'b1;
            end
            // widx is reused as the wipe index, restarting at word 0.
            if (fail_go) widx <= '0;
`endif
            if (state_nxt == S_ERR) error <= 1'b1;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_omsp_spm_key_loader.sv
`timescale 1ns/1ps
// Bench for omsp_spm_key_loader: directed scenarios plus random traffic, all checked cycle by cycle.
module tb_omsp_spm_key_loader;

  localparam int KW = 4;
  localparam int IW = 2;
  localparam int TO = 5;

  logic          mclk = 1'b0;
  logic          puc_rst;
  logic          start;
  logic          abort;
  logic          kdf_start;
  logic          kdf_valid;
  logic [15:0]   kdf_data;
  logic          kdf_ready;
  logic          write_key;
  logic [15:0]   key_in;
  logic [IW-1:0] key_idx;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    dbg_state;

  // ---------------- clock / reset ----------------
  always #5 mclk = ~mclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  omsp_spm_key_loader #(
    .KEY_WORDS   (KW),
    .KEY_IDX_SIZE(IW),
    .TIMEOUT     (TO)
  ) dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .start    (start),
    .abort    (abort),
    .kdf_start(kdf_start),
    .kdf_valid(kdf_valid),
    .kdf_data (kdf_data),
    .kdf_ready(kdf_ready),
    .write_key(write_key),
    .key_in   (key_in),
    .key_idx  (key_idx),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_KICK = 1, M_LOAD = 2, M_DONE = 3, M_WIPE = 4, M_ERR = 5;
  int  m_phase = M_IDLE;
  bit  m_live  = 1'b0;
  bit  m_err   = 1'b0;
  bit  m_wr    = 1'b0;
  int  m_words = 0;
  int  m_idle  = 0;
  int  m_wipe  = 0;
  logic [IW+15:0] exp_q[$];
  logic [IW+15:0] exp_word;

  task automatic model_step();
    bit hs;
    bit fail;
    if (puc_rst) begin
      m_live  = 1'b1;
      m_phase = M_IDLE;
      m_err   = 1'b0;
      m_wr    = 1'b0;
      exp_q.delete();
      return;
    end
    if (!m_live) return;
    m_wr = 1'b0;
    fail = 1'b0;
    hs   = 1'b0;
    case (m_phase)
      M_IDLE: if (start && !abort) begin
        m_phase = M_KICK; m_err = 1'b0; m_words = 0; m_idle = 0;
      end
      M_KICK: if (abort) fail = 1'b1; else m_phase = M_LOAD;
      M_LOAD: begin
        hs = kdf_valid;
        if (hs) begin
          m_wr = 1'b1;
          exp_q.push_back({IW'(m_words), kdf_data});
          m_words++;
          m_idle = 0;
        end
        if (abort) fail = 1'b1;
        else if (hs) begin
          if (m_words == KW) m_phase = M_DONE;
        end else if (m_idle == TO) fail = 1'b1;
        else m_idle++;
      end
      M_DONE: if (abort) fail = 1'b1; else m_phase = M_IDLE;
      M_WIPE: begin
        m_wr = 1'b1;
        exp_q.push_back({IW'(m_wipe), 16'h0000});
        m_wipe++;
        if (m_wipe == KW) begin m_phase = M_ERR; m_err = 1'b1; end
      end
      default: m_phase = M_IDLE;
    endcase
    if (fail) begin
`ifdef OMSP_SPM_KEY_ZEROIZE_EN
      m_phase = M_WIPE; m_wipe = 0;
`else
      m_phase = M_ERR; m_err = 1'b1;
`endif
    end
  endtask

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge mclk) begin
    if (m_live) begin
      chk("busy",      32'(busy),      32'(m_phase != M_IDLE));
      chk("kdf_start", 32'(kdf_start), 32'(m_phase == M_KICK));
      chk("kdf_ready", 32'(kdf_ready), 32'(m_phase == M_LOAD));
      chk("done",      32'(done),      32'(m_phase == M_DONE));
      chk("error",     32'(error),     32'(m_err));
      chk("write_key", 32'(write_key), 32'(m_wr));
      if (m_wr) begin
        if (exp_q.size() == 0) chk("exp_q_nonempty", 32'(exp_q.size()), 32'd1);
        else begin
          exp_word = exp_q.pop_front();
          chk("write_word", 32'({key_idx, key_in}), 32'(exp_word));
        end
      end
    end
    model_step();
  end

  // ---------------- driver tasks ----------------
  logic [15:0]   eng_words[4];
  int            eng_k = 0;
  logic          s_busy, s_start, s_ready, s_wr, s_done, s_err;
  logic [15:0]   s_data;
  logic [IW-1:0] s_idx;
  logic [2:0]    s_dbg;
  bit            seen_done;

  task automatic tick();
    @(negedge mclk);
    s_busy = busy; s_start = kdf_start; s_ready = kdf_ready; s_wr = write_key;
    s_done = done; s_err = error; s_data = key_in; s_idx = key_idx; s_dbg = dbg_state;
    if (done) seen_done = 1'b1;
    if (kdf_valid && kdf_ready) eng_k++;
    @(posedge mclk);
    #1;
  endtask

  task automatic drive(input bit st, input bit ab, input bit v);
    start     = st;
    abort     = ab;
    kdf_valid = v;
    kdf_data  = eng_words[eng_k % 4];
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      drive(1'b0, 1'b0, 1'b1);
      tick();
      n++;
    end while (s_busy && n < 60);
    chk(name, 32'(s_busy), 32'd0);
  endtask

  task automatic load_words(input logic [15:0] w0, w1, w2, w3);
    eng_words[0] = w0; eng_words[1] = w1; eng_words[2] = w2; eng_words[3] = w3;
    eng_k = 0;
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] w3;
  int          vprob;

  initial begin
    puc_rst = 1'b1;
    load_words(16'h0, 16'h0, 16'h0, 16'h0);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    puc_rst = 1'b0;
    tick();
    chk("reset_outputs", 32'({s_busy, s_start, s_ready, s_wr, s_done, s_err, s_idx, s_data}), 32'd0);
    chk("reset_state", 32'(s_dbg), 32'd0);

    // Nominal zero-wait load
    load_words(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    seen_done = 1'b0;
    drive(1'b1, 1'b0, 1'b1); tick();
    chk("nom_idle_at_start", 32'(s_busy), 32'd0);
    drive(1'b0, 1'b0, 1'b1); tick();
    chk("nom_kick", 32'({s_busy, s_start, s_ready}), 32'({1'b1, 1'b1, 1'b0}));
    drive(1'b0, 1'b0, 1'b1); tick();
    chk("nom_first_ready", 32'({s_ready, s_wr}), 32'({1'b1, 1'b0}));
    drive(1'b0, 1'b0, 1'b1); tick();
    chk("nom_write0", 32'({s_wr, s_idx, s_data}), 32'({1'b1, 2'd0, 16'h1111}));
    drive(1'b0, 1'b0, 1'b1); tick();
    chk("nom_write1", 32'({s_wr, s_idx, s_data}), 32'({1'b1, 2'd1, 16'h2222}));
    drive(1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    chk("nom_write3_done", 32'({s_done, s_wr, s_ready, s_idx, s_data}),
        32'({1'b1, 1'b1, 1'b0, 2'd3, 16'h4444}));
    drive(1'b0, 1'b0, 1'b1); tick();
    chk("nom_busy_fall", 32'({s_busy, s_done, s_err}), 32'd0);

    // Abort together with the final-word handshake
    load_words(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    w3 = eng_words[3];
    seen_done = 1'b0;
    drive(1'b1, 1'b0, 1'b1); tick();
    for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b0, 1'b1); tick(); end
    drive(1'b0, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b0); tick();
    chk("abort_last_write", 32'({s_done, s_wr, s_idx, s_data}), 32'({1'b0, 1'b1, 2'd3, w3}));
    wait_idle("abort_idle");
    chk("abort_error", 32'({seen_done, s_err}), 32'({1'b0, 1'b1}));

    // start together with abort in IDLE: nothing happens, error kept
    drive(1'b1, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    chk("start_abort_idle", 32'({s_busy, s_start, s_err}), 32'({1'b0, 1'b0, 1'b1}));

    // Backpressure: 3 idle cycles before word 2, plus a start pulse while busy
    load_words(16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3);
    seen_done = 1'b0;
    drive(1'b1, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    chk("bp_write2", 32'({s_wr, s_idx, s_data}), 32'({1'b1, 2'd2, 16'hC2C2}));
    wait_idle("bp_idle");
    chk("bp_done_no_error", 32'({seen_done, s_err}), 32'({1'b1, 1'b0}));

    // Timeout: engine silent after word 0
    load_words(16'h5555, 16'h6666, 16'h7777, 16'h8888);
    seen_done = 1'b0;
    drive(1'b1, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b0, 1'b0); tick(); end
    drive(1'b0, 1'b0, 1'b0); tick();
    chk("to_still_loading", 32'({s_ready, s_err}), 32'({1'b1, 1'b0}));
    drive(1'b0, 1'b0, 1'b0); tick();
    chk("to_left_load", 32'({s_ready, s_done}), 32'd0);
    wait_idle("to_idle");
    chk("to_error", 32'({seen_done, s_err}), 32'({1'b0, 1'b1}));

    // A later start clears error
    drive(1'b1, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    chk("restart_clears_error", 32'({s_busy, s_err}), 32'({1'b1, 1'b0}));
    wait_idle("restart_idle");

    // Reset during LOAD
    drive(1'b1, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1); tick();
    puc_rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1); tick();
    puc_rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0); tick();
    chk("midload_reset", 32'({s_busy, s_start, s_ready, s_wr, s_done, s_err, s_idx, s_data}), 32'd0);
    chk("midload_reset_state", 32'(s_dbg), 32'd0);

    // Random traffic
    vprob = 100;
    for (int c = 0; c < 2400; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(0, 2))
          0:       vprob = 20;
          1:       vprob = 65;
          default: vprob = 100;
        endcase
      end
      puc_rst   = ($urandom_range(0, 399) == 0);
      start     = ($urandom_range(0, 11) == 0);
      abort     = ($urandom_range(0, 59) == 0);
      kdf_valid = ($urandom_range(0, 99) < vprob);
      kdf_data  = 16'($urandom);
      tick();
    end
    puc_rst = 1'b0;
    wait_idle("random_idle");
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
